// File: rtl/fan_tach_if.sv
// Register-bus port of fan_tach_reg: request from the SoC, one-cycle response back.
// Optional feature of the attached block: FAN_TACH_IRQ_EN (stall interrupt).
interface fan_tach_if #(
  parameter int unsigned AddrWidth = 48
) ();
  // Handshake: the master raises reg_valid_i with write/addr/wdata/wstrb stable and
  // holds them until it sees reg_ready_o. The slave answers with a single-cycle
  // reg_ready_o pulse carrying reg_rdata_o/reg_error_o, then ignores valid for that
  // cycle, so every access occupies exactly two cycles.
  logic                 reg_valid_i;
  logic                 reg_write_i;
  logic [AddrWidth-1:0] reg_addr_i;
  logic [31:0]          reg_wdata_i;
  logic [3:0]           reg_wstrb_i;
  logic [31:0]          reg_rdata_o;
  logic                 reg_error_o;
  logic                 reg_ready_o;

  modport master (
    output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_rdata_o, reg_error_o, reg_ready_o
  );

  modport slave (
    input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_rdata_o, reg_error_o, reg_ready_o
  );
endinterface

// File: rtl/fan_tach_reg.sv
// Fan tachometer: synchronized, glitch-filtered tach edges counted over a gate window,
// with a register-bus responder. Define FAN_TACH_IRQ_EN to enable the stall interrupt.
module fan_tach_reg #(
  parameter int unsigned AddrWidth     = 48,
  parameter logic [31:0] DefaultWindow = 32'd50_000_000,
  parameter int unsigned FiltCycles    = 8,
  parameter int unsigned CountWidth    = 16
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic       tach_i,
  fan_tach_if.slave  bus,
  output logic       irq_o,
  output logic [0:0] dbg_state_o
);

  localparam logic [0:0]            StIdle   = 1'b0;
  localparam logic [0:0]            StResp   = 1'b1;
  localparam logic [7:0]            FiltLast = 8'(FiltCycles - 1);
  localparam logic [CountWidth-1:0] CntOne   = 1;
  localparam logic [31:0]           MinWin   = 32'd16;
  localparam logic [31:0]           BadData  = 32'hBADC_AB1E;

  // ---------------------------------------------------------------- input path
  logic       tach_s1, tach_s2;
  logic       filt_level, filt_level_d;
  logic [7:0] filt_cnt;
  logic       pulse;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      tach_s1      <= 1'b0;
      tach_s2      <= 1'b0;
      filt_level   <= 1'b0;
      filt_level_d <= 1'b0;
      filt_cnt     <= '0;
    end else begin
      tach_s1      <= tach_i;
      tach_s2      <= tach_s1;
      filt_level_d <= filt_level;
      // Any return to the current level restarts the stability count.
      if (tach_s2 == filt_level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FiltLast) begin
        filt_cnt   <= '0;
        filt_level <= tach_s2;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign pulse = filt_level & ~filt_level_d;

  // ---------------------------------------------------------------- bus decode
  logic [0:0]  state_q;
  logic [2:0]  idx;
  logic        full_strb;
  logic        accept;
  logic        ctrl_wr;
  logic        win_wr;
  logic        clr;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic                  en_q, ie_q;
  logic [31:0]           window_q;
  logic [31:0]           win_cnt;
  logic [CountWidth-1:0] live_q, count_q;
  logic                  live_ovf;
  logic                  st_valid, st_stall, st_ovf;

  assign idx       = bus.reg_addr_i[4:2];
  assign full_strb = &bus.reg_wstrb_i;
  assign accept    = (state_q == StIdle) && bus.reg_valid_i;
  assign ctrl_wr   = accept && bus.reg_write_i && full_strb && (idx == 3'd0);
  assign win_wr    = accept && bus.reg_write_i && full_strb && (idx == 3'd1);
  assign clr       = ctrl_wr && bus.reg_wdata_i[1];

  always_comb begin
    rsp_data = '0;
    rsp_err  = 1'b0;
    case (idx)
      3'd0: rsp_data = {29'd0, ie_q, 1'b0, en_q};
      3'd1: rsp_data = window_q;
      3'd2: rsp_data = 32'(count_q);
      3'd3: rsp_data = {29'd0, st_ovf, st_stall, st_valid};
      3'd4: rsp_data = 32'(live_q);
      default: begin
        rsp_data = BadData;
        rsp_err  = 1'b1;
      end
    endcase
    // Writes return no data; read-only targets flag the rejected write.
    if (bus.reg_write_i && (idx <= 3'd4)) begin
      rsp_data = '0;
      rsp_err  = (idx >= 3'd2);
    end
  end

  // ---------------------------------------------------------------- access FSM
  logic        ready_q, error_q;
  logic [31:0] rdata_q;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.reg_valid_i) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            error_q <= rsp_err;
            rdata_q <= rsp_data;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b0;
          error_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.reg_ready_o = ready_q;
  assign bus.reg_error_o = error_q;
  assign bus.reg_rdata_o = rdata_q;
  assign dbg_state_o     = state_q;

  // ---------------------------------------------------------------- control regs
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b1;
      ie_q     <= 1'b0;
      window_q <= DefaultWindow;
    end else begin
      if (ctrl_wr) begin
        en_q <= bus.reg_wdata_i[0];
        ie_q <= bus.reg_wdata_i[2];
      end
      if (win_wr) begin
        window_q <= (bus.reg_wdata_i < MinWin) ? MinWin : bus.reg_wdata_i;
      end
    end
  end

  // ---------------------------------------------------------------- window engine
  logic win_end;
  logic live_max;

  assign win_end  = en_q && (win_cnt == '0);
  assign live_max = &live_q;

  // OVF records that at least one pulse was dropped because LIVE was already full.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= DefaultWindow - 32'd1;
      live_q   <= '0;
      live_ovf <= 1'b0;
      count_q  <= '0;
      st_valid <= 1'b0;
      st_stall <= 1'b0;
      st_ovf   <= 1'b0;
    end else if (clr) begin
      win_cnt  <= window_q - 32'd1;
      live_q   <= '0;
      live_ovf <= 1'b0;
      count_q  <= '0;
      st_valid <= 1'b0;
      st_stall <= 1'b0;
      st_ovf   <= 1'b0;
    end else if (!en_q) begin
      win_cnt  <= window_q - 32'd1;
      live_q   <= '0;
      live_ovf <= 1'b0;
    end else if (win_end) begin
      count_q  <= (pulse && !live_max) ? live_q + CntOne : live_q;
      st_valid <= 1'b1;
      st_stall <= (live_q == '0) && !pulse;
      st_ovf   <= live_ovf | (pulse & live_max);
      live_q   <= '0;
      live_ovf <= 1'b0;
      win_cnt  <= window_q - 32'd1;
    end else begin
      win_cnt <= win_cnt - 32'd1;
      if (pulse) begin
        if (live_max) live_ovf <= 1'b1;
        else          live_q   <= live_q + CntOne;
      end
    end
  end

  // ---------------------------------------------------------------- interrupt
`ifdef FAN_TACH_IRQ_EN
  logic irq_q;
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= ie_q & st_stall;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.reg_addr_i[AddrWidth-1:5], bus.reg_addr_i[1:0]};

endmodule

// File: doc/fan_tach_reg.md
# fan_tach_reg

Fan tachometer reader and register-bus responder for the Xilinx FPGA top level. It complements the PWM fan driver by measuring the fan's open-drain tach output. The tach input is synchronized, glitch-filtered and its rising edges are counted over a programmable gate window. The block is attached to the SoC's external register-bus port in place of the error slave and exposes control, window, count and status registers.

## Interface
- AddrWidth, 48: register-bus address width; only addr[4:2] decoded, addr[1:0] ignored.
- DefaultWindow, 32'd50_000_000: WINDOW reset value in soc_clk cycles (1 s at 50 MHz).
- FiltCycles, 8: cycles the synchronized tach level must be stable before the filtered level changes; 2..255.
- CountWidth, 16: width of pulse counters, saturating.
- soc_clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tach_i  in  1  raw fan tach, asynchronous to soc_clk.
- reg_valid_i  in  1  request valid, held until reg_ready_o.
- reg_write_i  in  1  1 = write, 0 = read.
- reg_addr_i  in  AddrWidth  byte address.
- reg_wdata_i  in  32  write data.
- reg_wstrb_i  in  4  byte strobes; only all-ones writes take effect.
- reg_rdata_o  out  32  read data.
- reg_error_o  out  1  error response.
- reg_ready_o  out  1  response valid, one-cycle pulse.
- irq_o  out  1  stall interrupt; only active with FAN_TACH_IRQ_EN.

## Operation
- Input path: 2-FF synchronizer, then a filter counter. The filtered level flips after FiltCycles consecutive cycles of the opposite synchronized level. A filtered 0->1 transition is one pulse.
- Registers (offset, reset value):
  - 0x00 CTRL RW, 0x1. bit0 EN; bit1 CLR, write-1 self-clearing, reads 0; bit2 IE.
  - 0x04 WINDOW RW, DefaultWindow. Writes below 16 store 16.
  - 0x08 COUNT RO, 0. Pulse count of the last completed window.
  - 0x0C STATUS RO, 0. bit0 VALID = at least one window completed since enable or clear; bit1 STALL = last completed window had count 0; bit2 OVF = last completed window saturated.
  - 0x10 LIVE RO, 0. Pulse count in the current window.
  - Offsets 0x14-0x1C: rdata 32'hBADCAB1E, error 1, no state change.
- Access states: IDLE -> RESP. IDLE with reg_valid_i samples the request and performs the write. RESP drives ready/rdata/error for one cycle, then returns to IDLE regardless of valid. Back-to-back accesses therefore take 2 cycles each.
- Partial-strobe write to a valid register: ignored, error 0. Write to an RO register: ignored, error 1.
- Window engine:
  - Down-counter loads WINDOW-1 at window start.
  - When it reaches 0: COUNT <= LIVE plus any edge in that cycle; STATUS updates; LIVE <= 0; counter reloads from the current WINDOW value. A WINDOW write therefore takes effect at the next window start.
- LIVE saturates at 2^CountWidth-1. OVF is set for that window's result.
- EN=0: down-counter held at reload, LIVE held at 0, COUNT/STATUS retained, filter keeps running. The 0->1 transition of EN starts a full window.
- CLR: clears LIVE, COUNT and STATUS and restarts the window the cycle after the write. CLR takes priority over a window end in the same cycle.

## Timing
- Reset: reg_ready_o 0, reg_error_o 0, reg_rdata_o 0, irq_o 0; filter level 0; down-counter = DefaultWindow-1; all registers at their reset values.
- Register access latency: ready one cycle after valid is sampled in IDLE. Write side effects are visible to a read issued on the next access.
- Tach latency: a clean rising edge on tach_i increments LIVE 2 + FiltCycles + 1 cycles later.
- Window period is exactly WINDOW cycles. COUNT is updated in the cycle after the counter reaches 0.
- Reset mid-access or mid-window: state returns immediately to reset values and no response is issued.

## Configuration
- FAN_TACH_IRQ_EN defined: irq_o = CTRL.IE & STATUS.STALL, registered. It asserts in the cycle after the stall window's COUNT update and clears on CLR, on a non-zero window result, or on IE=0.
- FAN_TACH_IRQ_EN undefined: irq_o tied 0; CTRL.IE is stored and readable but has no effect.

## Test plan
- Reset defaults: read 0x00/0x04/0x08/0x0C -> 0x1, 0x02FAF080, 0, 0, each with ready one cycle after valid and error 0.
- Counting: WINDOW=1000, 10 clean pulses of 40-cycle period on tach_i -> COUNT=10 after the window end; VALID=1, STALL=0.
- Filtering: FiltCycles=8, 5-cycle glitches on tach_i -> LIVE stays 0; a 9-cycle high pulse -> LIVE=1.
- Saturation: CountWidth=4, WINDOW=1000, 20 pulses -> COUNT=15, OVF=1.
- Stall and IRQ (macro on): IE=1, no pulses for one window -> STALL=1 and irq_o=1; write CLR -> irq_o=0, STATUS=0, window restarts.
- Bus errors: read 0x18 -> rdata 0xBADCAB1E, error 1; write 0x08 -> error 1, COUNT unchanged; write 0x04 with wstrb 4'b0011 -> error 0, WINDOW unchanged; write WINDOW=3 -> reads back 16.
